// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver.
// Oversampled receive path (2-flop synchroniser, tick divider, 3-sample
// majority vote) feeding a frame FSM. Characters are written into a small
// first-word-fall-through FIFO with a valid/ready read port. Parity, framing
// and overrun errors are reported.
module uart_rx_param #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 7,
  parameter int PARITY      = 2,   // 0 = none, 1 = odd, 2 = even
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_perr,
  output logic                 valid,
  input  logic                 ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TICK_DIV = (CLK_FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W    = $clog2(TICK_DIV + 1);
  localparam int TW       = $clog2(OVERSAMPLE);
  localparam int M        = OVERSAMPLE / 2;
  localparam int BW       = $clog2(DATA_BITS);
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  // Receive front end
  logic             sync1;
  logic             rx_s;
  logic             rx_d;
  logic             fall;

  // Timing
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [TW-1:0]    tcnt;
  logic [TW-1:0]    tcnt_nxt;
  logic             decide;
  logic             clear_timing;

  // Frame FSM and datapath
  logic [2:0]           state;
  logic [BW-1:0]        bcnt;
  logic                 scnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 s_a;
  logic                 s_b;
  logic                 vote;
  logic                 exp_par;
  logic                 ferr_event;
  logic                 push_req;

  // FIFO
  logic [DATA_BITS:0] mem [FIFO_DEPTH];
  logic [DATA_BITS:0] head;
  logic [AW:0]        wptr;
  logic [AW:0]        rptr;
  logic               full;
  logic               pop;
  logic               push;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, whatever the statement order.
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= rxd;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  // Tick, tick index, vote and control decodes
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    tick     = (div_cnt == DIV_W'(TICK_DIV - 1));
    tcnt_nxt = tcnt + 1'b1;
    if (tcnt == TW'(OVERSAMPLE - 1)) tcnt_nxt = '0;
    fall     = rx_d & ~rx_s;
    decide   = tick && (tcnt_nxt == TW'(M + 1));
    vote     = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
    exp_par  = (PARITY == 1) ? ~(^shreg) : (^shreg);
    ferr_event   = (state == S_STOP) && decide && !vote;
    push_req     = (state == S_STOP) && decide && vote && (scnt == 1'(STOP_BITS - 1));
    // Realign to a new start edge, restart the break timer while the line is
    // low, and start the break timer afresh on a framing error.
    clear_timing = ((state == S_IDLE) && fall) || ((state == S_BREAK) && !rx_s) || ferr_event;
  end

  // Clock divider and oversample tick counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      tcnt    <= '0;
    end else if (clear_timing) begin
      div_cnt <= '0;
      tcnt    <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      tcnt    <= tcnt_nxt;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame FSM: start validation, LSB-first deserialisation, parity, stop, break
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      bcnt  <= '0;
      scnt  <= 1'b0;
      shreg <= '0;
      perr  <= 1'b0;
      s_a   <= 1'b0;
      s_b   <= 1'b0;
    end else begin
      // The first two of the three vote samples; the third is rx_s itself
      // in the decision cycle.
      if (tick && (tcnt_nxt == TW'(M - 1))) s_a <= rx_s;
      if (tick && (tcnt_nxt == TW'(M)))     s_b <= rx_s;

      case (state)
        S_IDLE: begin
          if (fall) state <= S_START;
        end
        S_START: begin
          if (decide) begin
            if (vote) begin
              state <= S_IDLE;            // glitch: silently ignore
            end else begin
              state <= S_DATA;
              bcnt  <= '0;
              shreg <= '0;
              perr  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (decide) begin
            shreg[bcnt] <= vote;
            if (bcnt == BW'(DATA_BITS - 1)) begin
              state <= (PARITY == 0) ? S_STOP : S_PARITY;
              scnt  <= 1'b0;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (decide) begin
            perr  <= vote ^ exp_par;
            state <= S_STOP;
            scnt  <= 1'b0;
          end
        end
        S_STOP: begin
          if (decide) begin
            if (!vote) begin
              state <= S_BREAK;
            end else if (scnt == 1'(STOP_BITS - 1)) begin
              state <= S_IDLE;            // do not wait out the stop bit
            end else begin
              scnt <= 1'b1;
            end
          end
        end
        S_BREAK: begin
          // Counters restart while the line is low, so reaching a wrap means
          // a full bit time of continuous high.
          if (tick && rx_s && (tcnt_nxt == '0)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered one-clock error pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_event;
      overrun   <= push_req && full && !pop;
    end
  end

  assign pop  = valid && ready;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal.
  assign push = push_req && (!full || pop);

  // FIFO pointers; the extra MSB separates full from empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; emptying the FIFO is done by the
    // pointers, and the read port is forced to zero while empty.
    if (push) mem[wptr[AW-1:0]] <= {perr, shreg};
  end

  assign head      = mem[rptr[AW-1:0]];
  assign valid     = (wptr != rptr);
  assign data      = valid ? head[DATA_BITS-1:0] : '0;
  assign data_perr = valid & head[DATA_BITS];
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for uart_rx_param.
// Three instances at a fast line rate (TICK_DIV = 4, 64 clk per bit):
//   a = 7 data bits, even parity, 1 stop; b = 8 data, no parity, 2 stop;
//   c = 7 data, odd parity, 1 stop.
// A table of single-frame vectors is applied in a loop; reset, glitch,
// exact latency, mid-frame reset and overrun/back-to-back are hand sequences.
module tb_uart_rx_param;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD_R = 15_625;
  localparam int OS     = 16;
  localparam int TD     = 4;
  localparam int BIT    = OS * TD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset   = 1'b0;
  logic [2:0] rxd_v   = 3'b111;
  logic [2:0] ready_v = 3'b000;

  logic [6:0] data_a, data_c;
  logic [7:0] data_b;
  logic perr_a, perr_b, perr_c, valid_a, valid_b, valid_c;
  logic busy_a, busy_b, busy_c, ferr_a, ferr_b, ferr_c, ovr_a, ovr_b, ovr_c;

  uart_rx_param #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .rxd(rxd_v[0]), .data(data_a), .data_perr(perr_a),
    .valid(valid_a), .ready(ready_v[0]), .busy(busy_a), .frame_err(ferr_a), .overrun(ovr_a));

  uart_rx_param #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .rxd(rxd_v[1]), .data(data_b), .data_perr(perr_b),
    .valid(valid_b), .ready(ready_v[1]), .busy(busy_b), .frame_err(ferr_b), .overrun(ovr_b));

  uart_rx_param #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS), .DATA_BITS(7),
                  .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset(reset), .rxd(rxd_v[2]), .data(data_c), .data_perr(perr_c),
    .valid(valid_c), .ready(ready_v[2]), .busy(busy_c), .frame_err(ferr_c), .overrun(ovr_c));

  // Indexable views of the three instances
  logic [7:0] data_o [3];
  logic [2:0] perr_o, valid_o, busy_o, ferr_o, ovr_o;
  always_comb begin
    data_o[0] = {1'b0, data_a};
    data_o[1] = data_b;
    data_o[2] = {1'b0, data_c};
  end
  assign perr_o  = {perr_c, perr_b, perr_a};
  assign valid_o = {valid_c, valid_b, valid_a};
  assign busy_o  = {busy_c, busy_b, busy_a};
  assign ferr_o  = {ferr_c, ferr_b, ferr_a};
  assign ovr_o   = {ovr_c, ovr_b, ovr_a};

  // Per-instance frame configuration
  int nbits_c [3] = '{7, 8, 7};
  int haspar_c[3] = '{1, 0, 1};
  int nstop_c [3] = '{1, 2, 1};

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Rising-edge counter; read only at negedges
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitors: count pulses and high cycles; record valid_a rise time
  int   ferr_cnt[3] = '{0, 0, 0};
  int   ferr_hi [3] = '{0, 0, 0};
  int   ovr_cnt [3] = '{0, 0, 0};
  int   ovr_hi  [3] = '{0, 0, 0};
  logic [2:0] ferr_q = 3'b000;
  logic [2:0] ovr_q  = 3'b000;
  logic va_q = 1'b0;
  int   rise_cyc = 0;
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ferr_o[i] === 1'b1) ferr_hi[i]++;
      if (ferr_o[i] === 1'b1 && ferr_q[i] !== 1'b1) ferr_cnt[i]++;
      if (ovr_o[i] === 1'b1) ovr_hi[i]++;
      if (ovr_o[i] === 1'b1 && ovr_q[i] !== 1'b1) ovr_cnt[i]++;
    end
    ferr_q = ferr_o;
    ovr_q  = ovr_o;
    if (valid_a === 1'b1 && va_q !== 1'b1) rise_cyc = cyc;
    va_q = valid_a;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_bit(input int sel, input logic b);
    rxd_v[sel] = b;
    repeat (BIT) @(negedge clk);
  endtask

  // stopv[0] is the first stop bit, stopv[1] the second
  task automatic send_frame(input int sel, input logic [7:0] ch, input logic par,
                            input logic [1:0] stopv);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nbits_c[sel]; i++) drive_bit(sel, ch[i]);
    if (haspar_c[sel] != 0) drive_bit(sel, par);
    for (int s = 0; s < nstop_c[sel]; s++) drive_bit(sel, stopv[s]);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] ch;
    logic       par;
    logic [1:0] stopv;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[11];

  logic [7:0] list7[11] = '{8'h33, 8'h54, 8'h27, 8'h1A, 8'h07, 8'h61, 8'h0F, 8'h2C, 8'h7E, 8'h40, 8'h55};
  logic [7:0] list8[11] = '{8'hB3, 8'h54, 8'hA7, 8'h1A, 8'h87, 8'hE1, 8'h0F, 8'h2C, 8'hFE, 8'h40, 8'h55};

  // Eleven back-to-back frames with ready low, then drain on consecutive clks
  task automatic overrun_run(input int sel);
    int         base_o, base_oh, base_f;
    logic [7:0] ch;
    base_o  = ovr_cnt[sel];
    base_oh = ovr_hi[sel];
    base_f  = ferr_cnt[sel];
    ready_v[sel] = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ch = (sel == 0) ? list7[i] : list8[i];
      send_frame(sel, ch, ^ch[6:0], 2'b11);
    end
    repeat (BIT) @(negedge clk);
    check("overrun_pulses", 32'(ovr_cnt[sel] - base_o), 32'd7);
    check("overrun_width", 32'(ovr_hi[sel] - base_oh), 32'd7);
    check("overrun_no_ferr", 32'(ferr_cnt[sel] - base_f), 32'd0);
    check("overrun_valid", 32'(valid_o[sel]), 32'd1);
    check("drain_0", 32'(data_o[sel]), 32'((sel == 0) ? list7[0] : list8[0]));
    ready_v[sel] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("drain_k", 32'(data_o[sel]), 32'((sel == 0) ? list7[k] : list8[k]));
    end
    @(negedge clk);
    check("drain_empty", 32'(valid_o[sel]), 32'd0);
    ready_v[sel] = 1'b0;
  endtask

  // Watchdog: the run is fixed-length, this only guards against a hang
  initial begin
    #(10 * 200_000);
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, base_f, base_fh, s;

    vecs[0]  = '{0, 8'h33, 1'b0, 2'b11, 1'b1, 8'h33, 1'b0, 0};
    vecs[1]  = '{0, 8'h33, 1'b1, 2'b11, 1'b1, 8'h33, 1'b1, 0};
    vecs[2]  = '{2, 8'h33, 1'b1, 2'b11, 1'b1, 8'h33, 1'b0, 0};
    vecs[3]  = '{2, 8'h33, 1'b0, 2'b11, 1'b1, 8'h33, 1'b1, 0};
    vecs[4]  = '{0, 8'h15, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1};
    vecs[5]  = '{1, 8'hA5, 1'b0, 2'b11, 1'b1, 8'hA5, 1'b0, 0};
    vecs[6]  = '{1, 8'h00, 1'b0, 2'b11, 1'b1, 8'h00, 1'b0, 0};
    vecs[7]  = '{1, 8'hFF, 1'b0, 2'b01, 1'b0, 8'h00, 1'b0, 1};
    vecs[8]  = '{0, 8'h7F, 1'b1, 2'b11, 1'b1, 8'h7F, 1'b0, 0};
    vecs[9]  = '{0, 8'h00, 1'b1, 2'b11, 1'b1, 8'h00, 1'b1, 0};
    vecs[10] = '{2, 8'h01, 1'b0, 2'b11, 1'b1, 8'h01, 1'b0, 0};

    // Reset with the line idle
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_errs", 32'({ferr_o, ovr_o}), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Glitch: 4 clk low is rejected exactly at the start decision
    base_f = ferr_cnt[0];
    t = cyc;
    rxd_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rxd_v[0] = 1'b1;
    repeat (34) @(negedge clk);
    check("glitch_busy_before", 32'(busy_a), 32'd1);
    @(negedge clk);
    check("glitch_busy_after", 32'(busy_a), 32'd0);
    repeat (3 * BIT) @(negedge clk);
    check("glitch_valid", 32'(valid_a), 32'd0);
    check("glitch_no_ferr", 32'(ferr_cnt[0] - base_f), 32'd0);
    check("glitch_elapsed", 32'(cyc - t), 32'(39 + 3 * BIT));

    // Exact latency: two synchroniser flops + registered edge detect, then
    // nine bits plus (M+1) ticks to the stop decision
    t = cyc;
    send_frame(0, 8'h33, 1'b0, 2'b11);
    repeat (BIT) @(negedge clk);
    check("latency", 32'(rise_cyc - t), 32'(3 + (9 * OS + OS / 2 + 1) * TD));
    check("latency_data", 32'(data_a), 32'h33);
    ready_v[0] = 1'b1;
    @(negedge clk);
    ready_v[0] = 1'b0;
    check("latency_popped", 32'(valid_a), 32'd0);

    // Table-driven single frames
    foreach (vecs[i]) begin
      s       = vecs[i].sel;
      base_f  = ferr_cnt[s];
      base_fh = ferr_hi[s];
      send_frame(s, vecs[i].ch, vecs[i].par, vecs[i].stopv);
      if (vecs[i].exp_ferr != 0) begin
        repeat (2) drive_bit(s, 1'b0);
        rxd_v[s] = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        check("break_busy", 32'(busy_o[s]), 32'd1);
      end
      rxd_v[s] = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      check("vec_valid", 32'(valid_o[s]), 32'(vecs[i].exp_valid));
      check("vec_data", 32'(data_o[s]), 32'(vecs[i].exp_data));
      check("vec_perr", 32'(perr_o[s]), 32'(vecs[i].exp_perr));
      check("vec_busy", 32'(busy_o[s]), 32'd0);
      check("vec_ferr", 32'(ferr_cnt[s] - base_f), 32'(vecs[i].exp_ferr));
      check("vec_ferr_width", 32'(ferr_hi[s] - base_fh), 32'(vecs[i].exp_ferr));
      if (valid_o[s]) begin
        ready_v[s] = 1'b1;
        @(negedge clk);
        ready_v[s] = 1'b0;
      end
      check("vec_popped", 32'(valid_o[s]), 32'd0);
    end

    // Reset mid-frame with one character already stored
    send_frame(0, 8'h54, 1'b1, 2'b11);
    repeat (BIT) @(negedge clk);
    check("mid_pre_valid", 32'(valid_a), 32'd1);
    base_f = ferr_cnt[0];
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    check("mid_pre_busy", 32'(busy_a), 32'd1);
    reset    = 1'b0;
    rxd_v[0] = 1'b1;
    @(negedge clk);
    check("mid_busy", 32'(busy_a), 32'd0);
    check("mid_valid", 32'(valid_a), 32'd0);
    check("mid_data", 32'(data_a), 32'd0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    check("mid_no_push", 32'(valid_a), 32'd0);
    check("mid_no_ferr", 32'(ferr_cnt[0] - base_f), 32'd0);
    check("mid_idle", 32'(busy_a), 32'd0);

    // Overrun and back-to-back on both frame formats
    overrun_run(0);
    overrun_run(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
